// File: rtl/mul_pkg.sv
// Shared types and default sizes for the shared-multiplier controller and its arbiter.
package mul_pkg;

    localparam int DEF_N_REQ = 2;
    localparam int DEF_OP_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after ptr.
module mul_rr_arb
    import mul_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant
);

    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] pick;

    genvar gi, gj;

    // Rotate so that the requester at ptr lands on bit 0.
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [N_REQ-1:0] terms;
            for (gj = 0; gj < N_REQ; gj++) begin : g_term
                assign terms[gj] = (ptr == ID_W'(gj)) & valid[(gi + gj) % N_REQ];
            end
            assign rot[gi] = |terms;
        end
    endgenerate

    // Lowest set bit of the rotated vector is the winner.
    assign pick = rot & (~rot + N_REQ'(1));

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unrot
            logic [N_REQ-1:0] terms;
            for (gj = 0; gj < N_REQ; gj++) begin : g_term
                assign terms[gj] = (ptr == ID_W'(gj)) & pick[(gi - gj + N_REQ) % N_REQ];
            end
            assign grant[gi] = |terms;
        end
    endgenerate

endmodule

// File: rtl/mul_share_ctrl.sv
// Time-shared multiplier: round-robin accepts one operand pair, multiplies it
// in one registered stage, then holds the result until the consumer takes it.
module mul_share_ctrl
    import mul_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    parameter  int OP_W  = DEF_OP_W,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_REQ-1:0]               req_valid_i,
    output logic [N_REQ-1:0]               req_ready_o,
    input  logic [N_REQ-1:0][OP_W-1:0]     req_a_i,
    input  logic [N_REQ-1:0][OP_W-1:0]     req_b_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [2*OP_W-1:0]              rsp_product_o,
    output logic [ID_W-1:0]                rsp_id_o,
    output logic                           busy_o
);

    state_t                 state_reg;
    logic [ID_W-1:0]        ptr_reg;
    logic [OP_W-1:0]        a_reg;
    logic [OP_W-1:0]        b_reg;
    logic [ID_W-1:0]        id_reg;
    logic [2*OP_W-1:0]      product_reg;
    logic                   rsp_valid_reg;
    logic                   busy_reg;

    logic [N_REQ-1:0]            arb_valid;
    logic [N_REQ-1:0]            grant;
    logic [N_REQ-1:0][OP_W-1:0]  a_masked;
    logic [N_REQ-1:0][OP_W-1:0]  b_masked;
    logic [OP_W-1:0]             sel_a;
    logic [OP_W-1:0]             sel_b;
    logic [ID_W-1:0]             grant_idx;
    logic [ID_W-1:0]             ptr_next;
    logic [2*OP_W-1:0]           product;

    // Requests are only offered to the arbiter while idle, so ready is zero elsewhere.
    assign arb_valid = (state_reg == IDLE) ? req_valid_i : '0;

    mul_rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .valid (arb_valid),
        .ptr   (ptr_reg),
        .grant (grant)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign a_masked[gi] = req_a_i[gi] & {OP_W{grant[gi]}};
            assign b_masked[gi] = req_b_i[gi] & {OP_W{grant[gi]}};
        end
    endgenerate

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_a = sel_a | a_masked[i];
            sel_b = sel_b | b_masked[i];
            if (grant[i]) begin
                grant_idx = ID_W'(i);
            end
        end
    end

    assign ptr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    assign product  = (2*OP_W)'(a_reg) * (2*OP_W)'(b_reg);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            id_reg        <= '0;
            product_reg   <= '0;
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|grant) begin
                        a_reg     <= sel_a;
                        b_reg     <= sel_b;
                        id_reg    <= grant_idx;
                        ptr_reg   <= ptr_next;
                        busy_reg  <= 1'b1;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    product_reg   <= product;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Outputs are forced low for the whole time reset is asserted, not just after the edge.
    assign req_ready_o   = rst_i ? '0 : grant;
    assign rsp_valid_o   = rsp_valid_reg & ~rst_i;
    assign rsp_product_o = rst_i ? '0 : product_reg;
    assign rsp_id_o      = rst_i ? '0 : id_reg;
    assign busy_o        = busy_reg & ~rst_i;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl with N_REQ=2, OP_W=4; expected values are hand-computed.
module tb_mul_share_ctrl;

    logic            clk;
    logic            rst_i;
    logic [1:0]      req_valid_i;
    logic [1:0]      req_ready_o;
    logic [1:0][3:0] req_a_i;
    logic [1:0][3:0] req_b_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [7:0]      rsp_product_o;
    logic [0:0]      rsp_id_o;
    logic            busy_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mul_share_ctrl #(
        .N_REQ (2),
        .OP_W  (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_a_i       (req_a_i),
        .req_b_i       (req_b_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_product_o (rsp_product_o),
        .rsp_id_o      (rsp_id_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        req_valid_i = 2'b11;
        req_a_i[0]  = 4'd9;  req_b_i[0] = 4'd9;
        req_a_i[1]  = 4'd7;  req_b_i[1] = 4'd7;
        rsp_ready_i = 1'b1;
        step();
        step();
        #1;
        total_cnt++; if (req_ready_o !== 2'b00) $display("FAIL reset_ready got=%b exp=%b", req_ready_o, 2'b00); else pass_cnt++;
        total_cnt++; if (rsp_valid_o !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid_o); else pass_cnt++;
        total_cnt++; if (rsp_product_o !== 8'd0) $display("FAIL reset_product got=%0d exp=0", rsp_product_o); else pass_cnt++;
        total_cnt++; if (rsp_id_o !== 1'b0) $display("FAIL reset_id got=%0d exp=0", rsp_id_o); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_o); else pass_cnt++;
        step();
        req_valid_i = 2'b00;
        rst_i       = 1'b0;
        $display("reset: outputs ready=%b valid=%b prod=%0d id=%0d busy=%b", req_ready_o, rsp_valid_o, rsp_product_o, rsp_id_o, busy_o);
    endtask

    task automatic test_single();
        step();
        req_valid_i = 2'b01;
        req_a_i[0]  = 4'd3;
        req_b_i[0]  = 4'd5;
        rsp_ready_i = 1'b1;
        #1;
        total_cnt++; if (req_ready_o !== 2'b01) $display("FAIL single_ready got=%b exp=01", req_ready_o); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL single_idle_busy got=%b exp=0", busy_o); else pass_cnt++;
        step();
        req_valid_i = 2'b00;
        #1;
        total_cnt++; if ({busy_o, rsp_valid_o, req_ready_o} !== 4'b1000) $display("FAIL single_calc got=%b exp=1000", {busy_o, rsp_valid_o, req_ready_o}); else pass_cnt++;
        step();
        #1;
        total_cnt++; if ({rsp_valid_o, rsp_product_o, rsp_id_o} !== {1'b1, 8'd15, 1'b0}) $display("FAIL single_rsp got=%b/%0d/%0d exp=1/15/0", rsp_valid_o, rsp_product_o, rsp_id_o); else pass_cnt++;
        step();
        #1;
        total_cnt++; if ({rsp_valid_o, busy_o} !== 2'b00) $display("FAIL single_done got=%b exp=00", {rsp_valid_o, busy_o}); else pass_cnt++;
        $display("single: req0 3*5 -> product=%0d id=%0d", dut.product_reg, dut.id_reg);
    endtask

    task automatic test_contention();
        logic [7:0] exp_prod [4];
        logic [1:0] exp_ready [4];
        exp_prod  = '{8'd14, 8'd54, 8'd14, 8'd54};
        exp_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
        step();
        rst_i = 1'b1;
        step();
        rst_i       = 1'b0;
        req_a_i[0]  = 4'd2;  req_b_i[0] = 4'd7;
        req_a_i[1]  = 4'd6;  req_b_i[1] = 4'd9;
        req_valid_i = 2'b11;
        rsp_ready_i = 1'b1;
        for (int t = 0; t < 4; t++) begin
            #1;
            total_cnt++; if (req_ready_o !== exp_ready[t]) $display("FAIL contention_grant%0d got=%b exp=%b", t, req_ready_o, exp_ready[t]); else pass_cnt++;
            step();
            #1;
            total_cnt++; if (req_ready_o !== 2'b00) $display("FAIL contention_calc_ready%0d got=%b exp=00", t, req_ready_o); else pass_cnt++;
            step();
            #1;
            total_cnt++; if ({rsp_valid_o, rsp_product_o, rsp_id_o} !== {1'b1, exp_prod[t], 1'(t % 2)}) $display("FAIL contention_rsp%0d got=%b/%0d/%0d exp=1/%0d/%0d", t, rsp_valid_o, rsp_product_o, rsp_id_o, exp_prod[t], t % 2); else pass_cnt++;
            $display("contention: txn %0d id=%0d product=%0d", t, rsp_id_o, rsp_product_o);
            step();
        end
        req_valid_i = 2'b00;
    endtask

    task automatic test_backpressure();
        req_valid_i = 2'b01;
        req_a_i[0]  = 4'd4;
        req_b_i[0]  = 4'd11;
        rsp_ready_i = 1'b0;
        #1;
        total_cnt++; if (req_ready_o !== 2'b01) $display("FAIL bp_grant got=%b exp=01", req_ready_o); else pass_cnt++;
        step();
        req_valid_i = 2'b11;
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++; if ({rsp_valid_o, rsp_product_o, rsp_id_o} !== {1'b1, 8'd44, 1'b0}) $display("FAIL bp_hold%0d got=%b/%0d/%0d exp=1/44/0", i, rsp_valid_o, rsp_product_o, rsp_id_o); else pass_cnt++;
            total_cnt++; if ({req_ready_o, busy_o} !== 3'b001) $display("FAIL bp_ready_busy%0d got=%b exp=001", i, {req_ready_o, busy_o}); else pass_cnt++;
            step();
        end
        rsp_ready_i = 1'b1;
        req_valid_i = 2'b00;
        step();
        #1;
        total_cnt++; if ({rsp_valid_o, busy_o} !== 2'b00) $display("FAIL bp_release got=%b exp=00", {rsp_valid_o, busy_o}); else pass_cnt++;
        $display("backpressure: req0 4*11 held 4 cycles, product=%0d", rsp_product_o);
    endtask

    task automatic test_boundary();
        req_valid_i = 2'b10;
        req_a_i[1]  = 4'd15;
        req_b_i[1]  = 4'd15;
        #1;
        total_cnt++; if (req_ready_o !== 2'b10) $display("FAIL bnd_grant1 got=%b exp=10", req_ready_o); else pass_cnt++;
        step();
        req_valid_i = 2'b00;
        step();
        #1;
        total_cnt++; if ({rsp_valid_o, rsp_product_o, rsp_id_o} !== {1'b1, 8'hE1, 1'b1}) $display("FAIL bnd_max got=%b/%0d/%0d exp=1/225/1", rsp_valid_o, rsp_product_o, rsp_id_o); else pass_cnt++;
        $display("boundary: req1 15*15 -> product=%0d", rsp_product_o);
        step();
        req_valid_i = 2'b01;
        req_a_i[0]  = 4'd0;
        req_b_i[0]  = 4'd9;
        #1;
        total_cnt++; if (req_ready_o !== 2'b01) $display("FAIL bnd_grant0 got=%b exp=01", req_ready_o); else pass_cnt++;
        step();
        req_valid_i = 2'b00;
        step();
        #1;
        total_cnt++; if ({rsp_valid_o, rsp_product_o, rsp_id_o} !== {1'b1, 8'd0, 1'b0}) $display("FAIL bnd_zero got=%b/%0d/%0d exp=1/0/0", rsp_valid_o, rsp_product_o, rsp_id_o); else pass_cnt++;
        $display("boundary: req0 0*9 -> product=%0d", rsp_product_o);
        step();
    endtask

    task automatic test_reset_mid_calc();
        req_valid_i = 2'b10;
        req_a_i[1]  = 4'd5;
        req_b_i[1]  = 4'd5;
        #1;
        total_cnt++; if (req_ready_o !== 2'b10) $display("FAIL rstcalc_grant got=%b exp=10", req_ready_o); else pass_cnt++;
        step();
        req_valid_i = 2'b00;
        rst_i       = 1'b1;
        #1;
        total_cnt++; if ({rsp_valid_o, busy_o} !== 2'b00) $display("FAIL rstcalc_in_reset got=%b exp=00", {rsp_valid_o, busy_o}); else pass_cnt++;
        step();
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++; if ({rsp_valid_o, busy_o} !== 2'b00) $display("FAIL rstcalc_no_rsp%0d got=%b exp=00", i, {rsp_valid_o, busy_o}); else pass_cnt++;
            step();
        end
        req_valid_i = 2'b11;
        req_a_i[0]  = 4'd3;  req_b_i[0] = 4'd4;
        req_a_i[1]  = 4'd7;  req_b_i[1] = 4'd7;
        #1;
        total_cnt++; if (req_ready_o !== 2'b01) $display("FAIL rstcalc_ptr0 got=%b exp=01", req_ready_o); else pass_cnt++;
        step();
        req_valid_i = 2'b00;
        step();
        #1;
        total_cnt++; if ({rsp_valid_o, rsp_product_o, rsp_id_o} !== {1'b1, 8'd12, 1'b0}) $display("FAIL rstcalc_rsp got=%b/%0d/%0d exp=1/12/0", rsp_valid_o, rsp_product_o, rsp_id_o); else pass_cnt++;
        $display("reset_mid_calc: aborted req1, then req0 3*4 -> product=%0d", rsp_product_o);
        step();
    endtask

    task automatic test_withdrawal();
        req_valid_i = 2'b01;
        req_a_i[0]  = 4'd2;
        req_b_i[0]  = 4'd2;
        #1;
        total_cnt++; if (req_ready_o !== 2'b01) $display("FAIL wd_grant0 got=%b exp=01", req_ready_o); else pass_cnt++;
        step();
        req_valid_i = 2'b10;
        #1;
        total_cnt++; if (req_ready_o !== 2'b00) $display("FAIL wd_busy_ready got=%b exp=00", req_ready_o); else pass_cnt++;
        step();
        req_valid_i = 2'b00;
        #1;
        total_cnt++; if ({rsp_valid_o, rsp_product_o, rsp_id_o, req_ready_o} !== {1'b1, 8'd4, 1'b0, 2'b00}) $display("FAIL wd_rsp got=%b/%0d/%0d/%b exp=1/4/0/00", rsp_valid_o, rsp_product_o, rsp_id_o, req_ready_o); else pass_cnt++;
        step();
        #1;
        total_cnt++; if ({req_ready_o, busy_o} !== 3'b000) $display("FAIL wd_idle got=%b exp=000", {req_ready_o, busy_o}); else pass_cnt++;
        step();
        req_valid_i = 2'b11;
        req_a_i[1]  = 4'd7;
        req_b_i[1]  = 4'd7;
        #1;
        total_cnt++; if (req_ready_o !== 2'b10) $display("FAIL wd_ptr_kept got=%b exp=10", req_ready_o); else pass_cnt++;
        step();
        req_valid_i = 2'b00;
        step();
        #1;
        total_cnt++; if ({rsp_valid_o, rsp_product_o, rsp_id_o} !== {1'b1, 8'd49, 1'b1}) $display("FAIL wd_rsp1 got=%b/%0d/%0d exp=1/49/1", rsp_valid_o, rsp_product_o, rsp_id_o); else pass_cnt++;
        $display("withdrawal: req1 withdrawn while busy, later 7*7 -> product=%0d id=%0d", rsp_product_o, rsp_id_o);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout after %0d checks", total_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_boundary();
        test_reset_mid_calc();
        test_withdrawal();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mul_share_ctrl.md
MUL_SHARE_CTRL -- requirements
Module: mul_share_ctrl

Interface
REQ-001 SHALL have parameter N_REQ, default 2, meaning number of requesters sharing the multiplier (2..4).
REQ-002 SHALL have parameter OP_W, default 4, meaning operand width; product width is 2*OP_W.
REQ-003 SHALL have port clk_i  input  1  clock; all logic updates on the rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid_i  input  N_REQ  per-requester operand valid.
REQ-006 SHALL have port req_ready_o  output  N_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 SHALL have port req_a_i  input  N_REQ x OP_W  operand A per requester.
REQ-008 SHALL have port req_b_i  input  N_REQ x OP_W  operand B per requester.
REQ-009 SHALL have port rsp_valid_o  output  1  result valid.
REQ-010 SHALL have port rsp_ready_i  input  1  result consumer ready.
REQ-011 SHALL have port rsp_product_o  output  2*OP_W  unsigned product.
REQ-012 SHALL have port rsp_id_o  output  clog2(N_REQ)  index of requester owning the result.
REQ-013 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, RESP.
REQ-015 In IDLE, req_ready_o SHALL be one-hot to the round-robin winner among asserted req_valid_i, all-zero if none valid.
REQ-016 Handshake (req_valid_i[k] & req_ready_o[k]) SHALL capture req_a_i[k], req_b_i[k] and k into operand registers and move IDLE->CALC.
REQ-017 In CALC, the registered unsigned product of the captured operands SHALL be loaded into the result register; CALC->RESP unconditionally (one cycle).
REQ-018 In RESP, rsp_valid_o SHALL be high; rsp_product_o and rsp_id_o SHALL stay stable until rsp_valid_o & rsp_ready_i.
REQ-019 On rsp handshake, state SHALL return to IDLE; the next grant occurs no earlier than the following cycle.
REQ-020 Latency SHALL be exactly 2 cycles from accept edge to rsp_valid_o high; throughput at most one result per 3 cycles.
REQ-021 Round-robin: priority pointer SHALL start at requester 0 and, after each grant to k, move to (k+1) mod N_REQ.
REQ-022 req_ready_o SHALL be all-zero in CALC and RESP regardless of req_valid_i.
REQ-023 Product SHALL be full width, no truncation: 15*15 = 225 (8'hE1) for OP_W=4.
REQ-024 A requester dropping req_valid_i without handshake SHALL not be granted and SHALL not affect pointer.

Reset
REQ-025 rst_i high at a clock edge SHALL force state IDLE, pointer 0, operand/result/id registers 0.
REQ-026 While in reset, all outputs SHALL be 0: req_ready_o, rsp_valid_o, rsp_product_o, rsp_id_o, busy_o.
REQ-027 Reset in CALC or RESP SHALL abort the transaction; no response for it is ever emitted.

Structure
REQ-028 State enum (IDLE, CALC, RESP) and default widths SHALL live in shared package mul_pkg.
REQ-029 Round-robin grant logic SHALL be a sub-module mul_rr_arb (inputs valid vector, pointer; output one-hot grant).
REQ-030 Multiplication SHALL be a combinational unsigned OP_W x OP_W multiply feeding the CALC-stage register.

Verification
REQ-031 Single request: req0 a=3,b=5 -> accepted cycle 0, rsp_valid cycle 2, product 15, id 0.
REQ-032 Contention: req0 and req1 valid continuously -> grants alternate 0,1,0,1; products correct per id.
REQ-033 Backpressure: rsp_ready_i low 4 cycles in RESP -> product/id stable, req_ready_o all zero, busy_o high.
REQ-034 Boundary: a=15,b=15 -> 225; a=0,b=9 -> 0.
REQ-035 Reset mid-CALC: rst_i one cycle -> no rsp_valid, next request served by requester 0 priority.
REQ-036 Valid withdrawal: req1 valid one cycle while busy, then low -> never granted, pointer unchanged.
